// File: rtl/dmem_arbiter_if.sv
// Requester and DataMemory signal bundle for dmem_arbiter.
// The arbiter takes the slave side; requesters and the memory sit on the master side.
interface dmem_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic        err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err0, err1, rdata0, rdata1,
               mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
               mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port DataMemory.
// One access per SERVE/RESP pair; bad addresses are acked with err and never touch memory.
module dmem_arbiter #(
    parameter int AW = 8
) (
    input logic          clk,
    input logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]       state;
    logic             last;
    logic             gnt;
    logic             l_we;
    logic [31:0]      l_addr;
    logic [31:0]      l_wdata;

    logic [1:0]       req, we;
    logic [1:0][31:0] addr, wdata;
    logic [1:0]       ack, err;
    logic [1:0][31:0] rdata;

    logic [1:0]       mask, elig;
    logic             grant_any, pick, bad;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

    // The port being acked in RESP is masked so a held request cannot win twice in a row.
    always_comb begin
        mask = 2'b00;
        if (state == S_RESP) mask = gnt ? 2'b10 : 2'b01;
        elig = 2'b00;
        if (state == S_IDLE || state == S_RESP) elig = req & ~mask;
        grant_any = |elig;
        pick      = (&elig) ? ~last : elig[1];
    end

    assign bad = (l_addr[31:AW+2] != '0) || (l_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            gnt     <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (grant_any) begin
                        state   <= S_SERVE;
                        gnt     <= pick;
                        last    <= pick;
                        l_we    <= we[pick];
                        l_addr  <= addr[pick];
                        l_wdata <= wdata[pick];
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SERVE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= '0;
            err   <= '0;
            rdata <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ack[i] <= 1'b0;
                err[i] <= 1'b0;
                if (state == S_SERVE && gnt == 1'(i)) begin
                    ack[i] <= 1'b1;
                    err[i] <= bad;
                    if (!l_we && !bad) rdata[i] <= bus.mem_rdata;
                end
            end
        end
    end

    // Write enable is decoded from registered state so an async reset kills it at once.
    assign bus.mem_we    = (state == S_SERVE) && l_we && !bad;
    assign bus.mem_addr  = l_addr;
    assign bus.mem_wdata = l_wdata;
    assign bus.busy      = (state != S_IDLE);

    assign bus.ack0   = ack[0];
    assign bus.ack1   = ack[1];
    assign bus.err0   = err[0];
    assign bus.err1   = err[1];
    assign bus.rdata0 = rdata[0];
    assign bus.rdata1 = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-write memory stub and an ack scoreboard.
module tb_dmem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dmem_arbiter_if bus();
    dmem_arbiter #(.AW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rd  [2];
    exp_t        q[$];
    int          ack_cyc[$];
    logic [31:0] serve_addr[$];
    int          rem[2];
    int          checks   = 0;
    int          failures = 0;
    int          we_pulses;
    int          ncyc;

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(negedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input bit p);
        return p ? bus.ack1 : bus.ack0;
    endfunction
    function automatic logic get_err(input bit p);
        return p ? bus.err1 : bus.err0;
    endfunction
    function automatic logic [31:0] get_rdata(input bit p);
        return p ? bus.rdata1 : bus.rdata0;
    endfunction

    task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    endtask

    task automatic set_req(input bit p, input bit r);
        if (p) bus.req1 = r; else bus.req0 = r;
    endtask

    // Queue the expected response for one service of port p and raise its request.
    task automatic issue(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   b;
        b = (a[31:10] != 0) || (a[1:0] != 0);
        if (!b) begin
            if (w) ref_mem[a[9:2]] = d;
            else   ref_rd[p] = ref_mem[a[9:2]];
        end
        e.port  = p;
        e.err   = b;
        e.rdata = ref_rd[p];
        q.push_back(e);
        rem[p]++;
        drive(p, 1'b1, w, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int max_cyc, output int nc);
        exp_t e;
        nc = 0;
        we_pulses = 0;
        ack_cyc.delete();
        serve_addr.delete();
        while (q.size() > 0 && nc < max_cyc) begin
            @(negedge clk);
            nc++;
            if (bus.mem_we) we_pulses++;
            if (bus.busy && !bus.ack0 && !bus.ack1) serve_addr.push_back(bus.mem_addr);
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p[0])) begin
                    ack_cyc.push_back(nc);
                    if (q.size() == 0) chk("spurious_ack", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("ack_port", p, 32'(e.port));
                        chk("err", 32'(get_err(p[0])), 32'(e.err));
                        chk("rdata", get_rdata(p[0]), e.rdata);
                        rem[p]--;
                        if (rem[p] == 0) set_req(p[0], 1'b0);
                    end
                end
            end
        end
        if (q.size() > 0) begin
            chk("ack_timeout", q.size(), 0);
            q.delete();
            rem[0] = 0; rem[1] = 0;
            set_req(1'b0, 1'b0);
            set_req(1'b1, 1'b0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        ref_rd[0] = '0; ref_rd[1] = '0;
        rem[0] = 0; rem[1] = 0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset values
        #1;
        chk("rst_ack", {bus.ack1, bus.ack0}, 0);
        chk("rst_err", {bus.err1, bus.err0}, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Single read of word 3
        issue(1'b0, 1'b0, 32'h0C, '0);
        run(10, ncyc);
        chk("rd_latency", ncyc, 3);
        chk("rd_serve_cycles", serve_addr.size(), 1);
        if (serve_addr.size() > 0) chk("rd_mem_addr", serve_addr[0], 32'h0C);
        chk("rd_no_write", we_pulses, 0);

        // Port 1 write then read-back at the top word
        idle(1);
        issue(1'b1, 1'b1, 32'h3FC, 32'h1234_5678);
        run(10, ncyc);
        chk("wr_latency", ncyc, 3);
        chk("wr_mem_we_pulses", we_pulses, 1);
        chk("wr_mem_word", mem[255], 32'h1234_5678);
        idle(1);
        issue(1'b1, 1'b0, 32'h3FC, '0);
        run(10, ncyc);
        chk("rb_no_write", we_pulses, 0);

        // Rejected addresses: out of range, misaligned, and a bad read
        idle(1);
        issue(1'b0, 1'b1, 32'h400, 32'hBAD0_BAD0);
        run(10, ncyc);
        chk("oor_mem_we", we_pulses, 0);
        idle(1);
        issue(1'b1, 1'b1, 32'h0D, 32'hBAD1_BAD1);
        run(10, ncyc);
        chk("mis_mem_we", we_pulses, 0);
        idle(1);
        issue(1'b0, 1'b0, 32'h0000_1000, '0);
        run(10, ncyc);
        chk("badrd_mem_we", we_pulses, 0);
        chk("bad_mem0", mem[0], ref_mem[0]);
        chk("bad_mem3", mem[3], ref_mem[3]);

        // Reset while a write is in SERVE
        idle(1);
        mem[8] = 32'h5555_5555; ref_mem[8] = 32'h5555_5555;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hAAAA_AAAA);
        @(posedge clk); #2;
        chk("mid_serve_we", bus.mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_we", bus.mem_we, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ack0", bus.ack0, 0);
        set_req(1'b0, 1'b0);
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(negedge clk);
        chk("arst_word", mem[8], 32'h5555_5555);
        chk("arst_rdata1", bus.rdata1, 0);
        rst_n = 1'b1;
        idle(1);

        // Tie from reset, both held: 0,1,0,1 every 2 cycles
        issue(1'b0, 1'b0, 32'h10, '0);
        issue(1'b1, 1'b0, 32'h14, '0);
        issue(1'b0, 1'b0, 32'h10, '0);
        issue(1'b1, 1'b0, 32'h14, '0);
        run(20, ncyc);
        chk("tie_acks", ack_cyc.size(), 4);
        if (ack_cyc.size() == 4) begin
            chk("tie_first", ack_cyc[0], 3);
            for (int i = 1; i < 4; i++) chk("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 2);
        end

        // Port 0 held through its ack while port 1 waits: 0,1,0
        idle(2);
        issue(1'b0, 1'b0, 32'h0C, '0);
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h3FC, '0);
        issue(1'b0, 1'b0, 32'h0C, '0);
        run(20, ncyc);
        chk("mask_acks", ack_cyc.size(), 3);
        if (ack_cyc.size() == 3) begin
            chk("mask_spacing1", ack_cyc[1] - ack_cyc[0], 2);
            chk("mask_spacing2", ack_cyc[2] - ack_cyc[1], 2);
        end

        idle(2);
        chk("end_busy", bus.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port `DataMemory` between the CPU load/store unit (port 0) and the DMA/debug loader (port 1). It accepts word requests on each port, grants one per service slot using round-robin priority, drives the memory's address, write-enable and write-data lines, and returns registered read data with a one-cycle `ack` pulse. It sits between the pipeline's MEM stage and the `DataMemory` instance. It also rejects out-of-range and misaligned addresses before they reach the memory.

## Interface
- `AW`, default 8: word-index width; valid byte addresses are `addr[AW+1:2]`, with `addr[31:AW+2]` == 0 and `addr[1:0]` == 0.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  access request; hold high with `we`/`addr`/`wdata` stable until `ack` of that port.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  32  byte address.
- `wdata0`, `wdata1`  in  32  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  valid with `ack`; 1 = rejected address, no memory access.
- `rdata0`, `rdata1`  out  32  registered read data; updated only on a read ack with `err`=0.
- `mem_addr`  out  32  to `DataMemory.in_addr`.
- `mem_we`  out  1  to `DataMemory.we`.
- `mem_wdata`  out  32  to `DataMemory.wdata`.
- `mem_rdata`  in  32  from `DataMemory.rdata` (combinational read).
- `busy`  out  1  1 while in SERVE or RESP.

## Operation
- States:
  - IDLE: no access in flight.
  - SERVE: the memory is driven for the granted port.
  - RESP: the `ack` cycle.
- Arbitration happens at the posedge in IDLE or RESP over the eligible requests.
  - In RESP, the request of the port being acked is masked (not eligible).
  - Exactly one eligible request: that port is granted.
  - Both eligible: the port not in `last` is granted; `last` ← granted port. `last` resets to 1, so port 0 wins the first tie.
  - A grant moves the FSM to SERVE. No eligible request: IDLE, or RESP→IDLE.
- On grant, the arbiter latches the granted port's `we`/`addr`/`wdata` and the port index into internal registers. All `mem_*` outputs come from these latched registers.
- Address check on the latched address: `bad` = (`addr[31:AW+2]` != 0) or (`addr[1:0]` != 0).
- SERVE lasts exactly 1 cycle.
  - `mem_we` = latched `we` & !`bad`.
  - `mem_addr` = latched addr.
  - `mem_wdata` = latched wdata.
  - At the posedge leaving SERVE:
    - On a read with !`bad`: `rdata[g]` ← `mem_rdata`.
    - Always: `ack[g]` ← 1 and `err[g]` ← `bad`.
    - FSM → RESP.
- RESP lasts 1 cycle. `ack`/`err` of the granted port are high in this cycle only. Arbitration for the next grant runs at the end of RESP.
- When `bad`, the memory is never written and `rdata` is unchanged.

## Timing
- Reset (async, immediate on `rst_n` low):
  - FSM = IDLE, `last` = 1.
  - `ack*`, `err*`, `mem_we`, `busy` = 0.
  - `rdata*`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-SERVE: `mem_we` drops immediately. No ack is issued, and the requester must re-request after reset.
- Latency: `req` is sampled high at edge E0 (arbiter in IDLE).
  - SERVE runs during cycle E0–E1.
  - `ack` is high during E1–E2, with `rdata` valid from E1.
  - Total: 2 cycles from request to ack.
- The write commits at the negedge inside the SERVE cycle, driven by the `DataMemory` negedge write. Address and data are stable for the whole cycle because they are registered.
- Throughput: one access every 2 cycles (SERVE, RESP, SERVE, …). Alternating ports are serviced back-to-back with no IDLE cycle between them.
- Requester rule: drop `req` (or present a new request) on the cycle after `ack`. A request held high through the `ack` cycle counts as a new request at the next arbitration.
- Both ports continuously requesting: strict alternation, and neither port waits more than 4 cycles.
- `mem_rdata` is sampled only at the end of SERVE; its value in other cycles is ignored.

## Test plan
- Single read: memory word 3 = 0xDEADBEEF; `req0` with `we0`=0, `addr0`=0x0C.
  - `mem_addr`=0x0C during SERVE.
  - `ack0` 2 cycles after request, `rdata0`=0xDEADBEEF, `err0`=0.
- Write then read-back on port 1: write 0x12345678 to `addr1`=0x3FC, then read 0x3FC.
  - Write: `mem_we`=1 for exactly one cycle.
  - Read: `rdata1`=0x12345678.
- Tie and fairness: `req0` and `req1` both high from reset and held.
  - Grant order 0, 1, 0, 1; ack pulses every 2 cycles, alternating.
- Rejected address: writes to 0x400 (out of range) and 0x0D (misaligned).
  - `ack`=1, `err`=1, `mem_we` stays 0 throughout.
  - Memory contents and `rdata` unchanged.
- Reset during SERVE of a write: pull `rst_n` low mid-cycle.
  - `mem_we`, `busy`, `ack` go to 0 without waiting for a clock edge.
  - Target word unchanged if reset precedes the negedge.
  - After reset release, the first tie goes to port 0.
- Held-request masking: `req0` held high through its ack cycle with `req1` high.
  - Port 1 is granted next; port 0 is re-served after port 1.
